// File: rtl/log_window_gen.sv
// Streaming 5x5 window generator: four line buffers plus a 5x5 shift array.
// Emits a packed window for every fully interior centre pixel, with a valid/ready handshake.
module log_window_gen #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   pix_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [199:0] window_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned K     = 5;
    localparam int unsigned LB_N  = K - 1;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned WIN_W = PIX_W * K * K;

    logic [PIX_W-1:0] lb_q    [LB_N][IMG_WIDTH];
    logic [PIX_W-1:0] win_q   [K][K];
    logic [PIX_W-1:0] win_d   [K][K];
    logic [PIX_W-1:0] new_col [K];

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             accept, emit, col_end, row_end;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign col_end    = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_end    = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign emit       = accept && (row_q >= ROW_W'(4)) && (col_q >= COL_W'(4));

    assign window_out = window_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;

    // Incoming column, oldest line (i=0) to current pixel (i=4), then the post-shift window.
    always_comb begin
        for (int unsigned i = 0; i < LB_N; i++) begin
            new_col[i] = lb_q[LB_N-1-i][col_q];
        end
        new_col[K-1] = pix_in;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][K-1] = new_col[i];
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        window_d    = window_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // A new window can only load when the old one is gone or leaving this cycle.
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = row_end && col_end;
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    window_d[PIX_W*(K*i+j) +: PIX_W] = win_d[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            window_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            window_q    <= window_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Pixel storage is not reset; emission gating guarantees it is refilled before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[0][col_q] <= pix_in;
            for (int unsigned i = 1; i < LB_N; i++) begin
                lb_q[i][col_q] <= lb_q[i-1][col_q];
            end
            win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_log_window_gen.sv
// Directed bench for log_window_gen on an 8x8 image: full rate, stall, random gaps,
// back-to-back frames, mid-frame reset and full-rate valid-run structure.
module tb_log_window_gen;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NWIN = (W - 4) * (H - 4);

    logic         clk;
    logic         rst;
    logic [7:0]   pix_in;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] window_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    int n_checks;
    int n_errors;

    logic [199:0] rx_win  [$];
    logic         rx_last [$];
    int           rx_cnt;
    int           runs    [$];
    int           run_len;
    logic         track_runs;

    log_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .window_out(window_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int fr, input int idx);
        return (fr == 0) ? 8'(idx) : 8'(255 - idx);
    endfunction

    function automatic logic [199:0] exp_win(input int fr, input int n);
        logic [199:0] w;
        int r, c;
        r = 4 + n / (W - 4);
        c = 4 + n % (W - 4);
        w = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                w[8*(5*i+j) +: 8] = pix(fr, (r - 4 + i) * W + (c - 4 + j));
            end
        end
        return w;
    endfunction

    // Handshakes are sampled on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rx_win.push_back(window_out);
            rx_last.push_back(out_last);
            rx_cnt++;
        end
        if (!rst && track_runs) begin
            if (out_valid) begin
                run_len++;
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
        end
    end

    task automatic clear_rx();
        rx_win.delete();
        rx_last.delete();
        rx_cnt = 0;
    endtask

    // mode 0: full rate, 1: full rate with a 5-cycle stall at window 3, 2: random gaps/ready
    task automatic drive_pixels(input int fr, input int count, input int mode);
        int idx = 0;
        int budget = 0;
        logic stalled = 1'b0;
        logic [199:0] held;
        while (idx < count && budget < 5000) begin
            @(posedge clk); #1;
            if (mode == 1 && !stalled && out_valid && rx_cnt == 2) begin
                stalled = 1'b1;
                held = window_out;
                for (int k = 0; k < 5; k++) begin
                    in_valid  = 1'b1;
                    pix_in    = pix(fr, idx);
                    out_ready = 1'b0;
                    @(negedge clk);
                    check_eq("stall_out_valid", 200'(out_valid), 200'(1));
                    check_eq("stall_window", window_out, held);
                    check_eq("stall_in_ready", 200'(in_ready), 200'(0));
                    @(posedge clk); #1;
                end
            end
            in_valid  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_in    = pix(fr, idx);
            @(negedge clk);
            if (mode == 0) check_eq("full_rate_in_ready", 200'(in_ready), 200'(1));
            if (in_valid && in_ready) idx++;
            budget++;
        end
        if (budget >= 5000) check_eq("drive_timeout", 200'(0), 200'(1));
    endtask

    task automatic drain();
        repeat (4) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic compare_frame(input string tag, input int fr, input int base);
        for (int n = 0; n < NWIN; n++) begin
            if (base + n < rx_win.size()) begin
                check_eq({tag, "_window"}, rx_win[base+n], exp_win(fr, n));
                check_eq({tag, "_last"}, 200'(rx_last[base+n]), 200'(n == NWIN - 1));
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rx_cnt     = 0;
        run_len    = 0;
        track_runs = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        pix_in     = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_out_valid", 200'(out_valid), 200'(0));
        check_eq("reset_out_last", 200'(out_last), 200'(0));
        check_eq("reset_window", window_out, 200'(0));
        check_eq("reset_in_ready", 200'(in_ready), 200'(1));

        // Test 1: full-rate frame
        clear_rx();
        drive_pixels(0, W * H, 0);
        drain();
        check_eq("t1_count", 200'(rx_cnt), 200'(16));
        if (rx_win.size() == 16) begin
            check_eq("t1_first_centre", 200'(rx_win[0][103:96]), 200'(18));
            check_eq("t1_first_corner", 200'(rx_win[0][199:192]), 200'(36));
            check_eq("t1_last_centre", 200'(rx_win[15][103:96]), 200'(45));
        end
        compare_frame("t1", 0, 0);

        // Test 2: stall at window 3
        clear_rx();
        drive_pixels(0, W * H, 1);
        drain();
        check_eq("t2_count", 200'(rx_cnt), 200'(16));
        compare_frame("t2", 0, 0);

        // Test 3: random in_valid gaps and out_ready
        clear_rx();
        drive_pixels(0, W * H, 2);
        drain();
        check_eq("t3_count", 200'(rx_cnt), 200'(16));
        compare_frame("t3", 0, 0);

        // Test 4: back-to-back frames, second one inverted
        clear_rx();
        drive_pixels(0, W * H, 0);
        drive_pixels(1, W * H, 0);
        drain();
        check_eq("t4_count", 200'(rx_cnt), 200'(32));
        if (rx_win.size() == 32) begin
            check_eq("t4_f2_first_centre", 200'(rx_win[16][103:96]), 200'(237));
        end
        compare_frame("t4_f1", 0, 0);
        compare_frame("t4_f2", 1, 16);

        // Test 5: reset after 20 pixels, then a full frame
        clear_rx();
        drive_pixels(1, 20, 0);
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_post_reset_valid", 200'(out_valid), 200'(0));
        check_eq("t5_post_reset_last", 200'(out_last), 200'(0));
        clear_rx();
        drive_pixels(0, W * H, 0);
        drain();
        check_eq("t5_count", 200'(rx_cnt), 200'(16));
        compare_frame("t5", 0, 0);

        // Test 6: full-rate valid runs, one burst of 4 per emitting row
        clear_rx();
        runs.delete();
        run_len    = 0;
        track_runs = 1'b1;
        drive_pixels(0, W * H, 0);
        drain();
        track_runs = 1'b0;
        check_eq("t6_run_count", 200'(runs.size()), 200'(4));
        foreach (runs[k]) check_eq("t6_run_len", 200'(runs[k]), 200'(4));
        check_eq("t6_count", 200'(rx_cnt), 200'(16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
